// File: rtl/pulse_train_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_train_pkg
// Description : Shared types and default widths for the pulse train generator.
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_train_pkg;

  // Default width of the pulse count and pulses_sent.
  localparam int c_cnt_w_default = 32;
  // Default width of the high/low phase lengths.
  localparam int c_ph_w_default  = 16;

  // Generator state: idle, driving a high phase, or in the gap between pulses.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pulse_train_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : pulse_train_gen_if
// Description : Control/status bundle of the pulse train generator. The master
//               side requests trains and reads status; the slave side is the
//               generator itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface pulse_train_gen_if
  import pulse_train_pkg::*;
#(
  parameter int CNT_W = c_cnt_w_default,
  parameter int PH_W  = c_ph_w_default
);

  logic             start;
  logic             stop;
  logic [CNT_W-1:0] num_pulses;
  logic [PH_W-1:0]  high_cycles;
  logic [PH_W-1:0]  low_cycles;
  logic             pulse_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pulses_sent;

  modport master (
    output start, stop, num_pulses, high_cycles, low_cycles,
    input  pulse_out, busy, done, pulses_sent
  );

  modport slave (
    input  start, stop, num_pulses, high_cycles, low_cycles,
    output pulse_out, busy, done, pulses_sent
  );

endinterface
`default_nettype wire

// File: rtl/pulse_train_gen_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : phase_timer
// Description : Loadable down-counter timing one high or low phase. A length
//               of 0 is stretched to 1 so adjacent pulses can never merge.
//               'expired' is high during the last cycle of the phase.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_timer
  import pulse_train_pkg::*;
#(
  parameter int PH_W = c_ph_w_default
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            load,
  input  wire logic [PH_W-1:0] len,
  input  wire logic            en,
  output logic                 expired
);

  logic [PH_W-1:0] r_cnt;
  logic [PH_W-1:0] w_len_eff;

  assign w_len_eff = (len == '0) ? PH_W'(1) : len;
  // r_cnt holds the cycles left in the phase, including the current one.
  assign expired   = (r_cnt <= PH_W'(1));

  // Load a new phase length, otherwise count down while the phase runs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= w_len_eff;
    end else if (en && !expired) begin
      r_cnt <= r_cnt - PH_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pulse_train_gen.sv
`default_nettype none
// ============================================================================
// Module      : pulse_train_gen
// Description : Emits an exact, programmable number of high pulses with
//               programmable high/low phase lengths. All outputs registered.
//               Optional macro PULSE_TRAIN_FREE_RUN_EN: when defined, a
//               num_pulses of 0 runs the train until stop or reset.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_train_gen
  import pulse_train_pkg::*;
#(
  parameter int CNT_W = c_cnt_w_default,
  parameter int PH_W  = c_ph_w_default
) (
  input  wire logic         clk,
  input  wire logic         rst,
  pulse_train_gen_if.slave  bus
);

  state_t           r_state;
  logic             r_pulse_out;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_pulses_sent;
  logic [CNT_W-1:0] r_num;
  logic [PH_W-1:0]  r_high;
  logic [PH_W-1:0]  r_low;
  logic             r_free_run;

  logic             w_accept;
  logic             w_free_run_req;
  logic             w_launch;
  logic             w_last;
  logic             w_expired;
  logic             w_tmr_load;
  logic [PH_W-1:0]  w_tmr_len;
  logic             w_tmr_en;

`ifdef PULSE_TRAIN_FREE_RUN_EN
  assign w_free_run_req = (bus.num_pulses == '0);
`else
  assign w_free_run_req = 1'b0;
`endif

  // stop in IDLE wins over a simultaneous start.
  assign w_accept = (r_state == IDLE) && bus.start && !bus.stop;
  assign w_launch = w_accept && ((bus.num_pulses != '0) || w_free_run_req);
  assign w_last   = !r_free_run && (r_pulses_sent == r_num);
  assign w_tmr_en = (r_state != IDLE);

  // One timer serves both phases: reload it at every phase boundary.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_len  = r_high;
    case (r_state)
      IDLE: begin
        if (w_launch) begin
          w_tmr_load = 1'b1;
          w_tmr_len  = bus.high_cycles;
        end
      end
      HIGH: begin
        if (!bus.stop && w_expired && !w_last) begin
          w_tmr_load = 1'b1;
          w_tmr_len  = r_low;
        end
      end
      LOW: begin
        if (!bus.stop && w_expired) begin
          w_tmr_load = 1'b1;
          w_tmr_len  = r_high;
        end
      end
      default: begin
        w_tmr_load = 1'b0;
      end
    endcase
  end

  phase_timer #(
    .PH_W (PH_W)
  ) u_phase_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (w_tmr_load),
    .len     (w_tmr_len),
    .en      (w_tmr_en),
    .expired (w_expired)
  );

  // Train sequencing FSM with registered outputs and the pulse counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_pulse_out   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pulses_sent <= '0;
      r_num         <= '0;
      r_high        <= '0;
      r_low         <= '0;
      r_free_run    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_num      <= bus.num_pulses;
            r_high     <= bus.high_cycles;
            r_low      <= bus.low_cycles;
            r_free_run <= w_free_run_req;
            if (w_launch) begin
              // Entering the first HIGH counts the first pulse.
              r_state       <= HIGH;
              r_pulse_out   <= 1'b1;
              r_busy        <= 1'b1;
              r_pulses_sent <= CNT_W'(1);
            end else begin
              r_pulses_sent <= '0;
              r_done        <= 1'b1;
            end
          end
        end
        HIGH: begin
          if (bus.stop) begin
            r_state     <= IDLE;
            r_pulse_out <= 1'b0;
            r_busy      <= 1'b0;
          end else if (w_expired) begin
            r_pulse_out <= 1'b0;
            if (w_last) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= LOW;
            end
          end
        end
        LOW: begin
          if (bus.stop) begin
            r_state     <= IDLE;
            r_pulse_out <= 1'b0;
            r_busy      <= 1'b0;
          end else if (w_expired) begin
            r_state       <= HIGH;
            r_pulse_out   <= 1'b1;
            r_pulses_sent <= r_pulses_sent + CNT_W'(1);
          end
        end
        default: begin
          r_state     <= IDLE;
          r_pulse_out <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pulse_out   = r_pulse_out;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.pulses_sent = r_pulses_sent;

endmodule
`default_nettype wire

// File: tb/tb_pulse_train_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_train_gen
// Description : Self-checking bench for pulse_train_gen: table of trains with
//               expected shape, plus hand sequences for zero count, abort,
//               back-to-back start and mid-train reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_train_gen;
  import pulse_train_pkg::*;

  logic clk;
  logic rst;

  pulse_train_gen_if #(.CNT_W(32), .PH_W(16)) bus ();

  pulse_train_gen #(.CNT_W(32), .PH_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] n;
    logic [15:0] h;
    logic [15:0] l;
    int          exp_busy;
    int          exp_hi;
    int          exp_lo;
  } vec_t;

  typedef struct {
    int pulses;
    int busy;
    int hi;
    int lo;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Launch one train, measure it until done, compare against the scoreboard.
  task automatic run_train(input vec_t v, input string tag);
    exp_t e;
    exp_t got;
    int   busy_cnt = 0;
    int   highs    = 0;
    int   hi_cyc   = 0;
    int   lo_cyc   = 0;
    bit   prev     = 1'b0;
    bit   got_done = 1'b0;
    e.pulses = int'(v.n);
    e.busy   = v.exp_busy;
    e.hi     = v.exp_hi;
    e.lo     = v.exp_lo;
    sb.push_back(e);
    bus.start       = 1'b1;
    bus.num_pulses  = v.n;
    bus.high_cycles = v.h;
    bus.low_cycles  = v.l;
    tick();
    bus.start       = 1'b0;
    bus.num_pulses  = 32'($urandom);
    bus.high_cycles = 16'($urandom);
    bus.low_cycles  = 16'($urandom);
    check({tag, "_latency_pulse"}, 32'(bus.pulse_out), 32'd1);
    check({tag, "_latency_busy"}, 32'(bus.busy), 32'd1);
    for (int c = 0; c < 2000 && !got_done; c++) begin
      if (bus.done) begin
        got_done = 1'b1;
      end else begin
        if (bus.busy) busy_cnt++;
        if (bus.pulse_out) begin
          hi_cyc++;
          if (!prev) highs++;
        end else if (bus.busy) begin
          lo_cyc++;
        end
        prev = bus.pulse_out;
        tick();
      end
    end
    check({tag, "_done_seen"}, 32'(got_done), 32'd1);
    got = sb.pop_front();
    check({tag, "_pulses"}, 32'(highs), 32'(got.pulses));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(got.busy));
    check({tag, "_high_cycles"}, 32'(hi_cyc), 32'(got.hi));
    check({tag, "_low_cycles"}, 32'(lo_cyc), 32'(got.lo));
    check({tag, "_pulses_sent"}, bus.pulses_sent, 32'(got.pulses));
    tick();
    check({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
    check({tag, "_sent_hold"}, bus.pulses_sent, 32'(got.pulses));
  endtask

  initial begin
    vec_t vecs[6];
    int   highs;
    bit   prev;
    bit   got;
    bit   saw_done;

    vecs[0] = '{n: 32'd4, h: 16'd2, l: 16'd3, exp_busy: 17, exp_hi: 8,  exp_lo: 9};
    vecs[1] = '{n: 32'd3, h: 16'd0, l: 16'd0, exp_busy: 5,  exp_hi: 3,  exp_lo: 2};
    vecs[2] = '{n: 32'd1, h: 16'd5, l: 16'd7, exp_busy: 5,  exp_hi: 5,  exp_lo: 0};
    vecs[3] = '{n: 32'd2, h: 16'd1, l: 16'd4, exp_busy: 6,  exp_hi: 2,  exp_lo: 4};
    vecs[4] = '{n: 32'd5, h: 16'd3, l: 16'd1, exp_busy: 19, exp_hi: 15, exp_lo: 4};
    vecs[5] = '{n: 32'd3, h: 16'd0, l: 16'd6, exp_busy: 15, exp_hi: 3,  exp_lo: 12};

    rst             = 1'b0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.num_pulses  = '0;
    bus.high_cycles = '0;
    bus.low_cycles  = '0;
    repeat (3) tick();
    check("rst_pulse_out", 32'(bus.pulse_out), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_pulses_sent", bus.pulses_sent, 32'd0);
    rst = 1'b1;
    tick();

    // Table of complete trains.
    for (int i = 0; i < 6; i++) begin
      run_train(vecs[i], $sformatf("vec%0d", i));
    end

`ifdef PULSE_TRAIN_FREE_RUN_EN
    // Free run: N=0 toggles until stop; stop after the 10th pulse.
    bus.start = 1'b1; bus.num_pulses = 32'd0; bus.high_cycles = 16'd1; bus.low_cycles = 16'd1;
    tick();
    bus.start = 1'b0;
    got = 1'b0; saw_done = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      if (bus.done) saw_done = 1'b1;
      if (bus.pulse_out && bus.pulses_sent == 32'd10) got = 1'b1;
      else tick();
    end
    check("free_reach10", 32'(got), 32'd1);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("free_stop_pulse", 32'(bus.pulse_out), 32'd0);
    check("free_stop_busy", 32'(bus.busy), 32'd0);
    check("free_stop_done", 32'(bus.done | saw_done), 32'd0);
    check("free_stop_sent", bus.pulses_sent, 32'd10);
    tick();
`else
    // Zero count: immediate done, no pulse, counter cleared.
    bus.start = 1'b1; bus.num_pulses = 32'd0; bus.high_cycles = 16'd3; bus.low_cycles = 16'd3;
    tick();
    bus.start = 1'b0;
    check("zero_done", 32'(bus.done), 32'd1);
    check("zero_busy", 32'(bus.busy), 32'd0);
    check("zero_pulse", 32'(bus.pulse_out), 32'd0);
    check("zero_sent", bus.pulses_sent, 32'd0);
    tick();
    check("zero_done_drop", 32'(bus.done), 32'd0);
    check("zero_pulse_after", 32'(bus.pulse_out), 32'd0);
`endif

    // Abort during the 6th high of a long train.
    bus.start = 1'b1; bus.num_pulses = 32'd100; bus.high_cycles = 16'd1; bus.low_cycles = 16'd1;
    tick();
    bus.start = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      if (bus.pulse_out && bus.pulses_sent == 32'd6) got = 1'b1;
      else tick();
    end
    check("abort_reach6", 32'(got), 32'd1);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("abort_pulse", 32'(bus.pulse_out), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_sent", bus.pulses_sent, 32'd6);
    // stop in IDLE beats a simultaneous start.
    bus.start = 1'b1; bus.stop = 1'b1; bus.num_pulses = 32'd3;
    tick();
    bus.start = 1'b0; bus.stop = 1'b0;
    check("stopstart_busy", 32'(bus.busy), 32'd0);
    check("stopstart_done", 32'(bus.done), 32'd0);
    check("stopstart_sent", bus.pulses_sent, 32'd6);
    run_train('{n: 32'd2, h: 16'd1, l: 16'd1, exp_busy: 3, exp_hi: 2, exp_lo: 1}, "retry");

    // Repeated start during a train is ignored; start in the done cycle is taken.
    bus.start = 1'b1; bus.num_pulses = 32'd5; bus.high_cycles = 16'd2; bus.low_cycles = 16'd2;
    tick();
    highs = 0; prev = 1'b0; got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      if (bus.done) begin
        got = 1'b1;
      end else begin
        if (bus.pulse_out && !prev) highs++;
        prev = bus.pulse_out;
        bus.start      = 1'($urandom_range(0, 1));
        bus.num_pulses = 32'($urandom_range(1, 9));
        tick();
      end
    end
    check("b2b_done_seen", 32'(got), 32'd1);
    check("b2b_pulses", 32'(highs), 32'd5);
    check("b2b_sent", bus.pulses_sent, 32'd5);
    bus.start = 1'b1; bus.num_pulses = 32'd1; bus.high_cycles = 16'd3; bus.low_cycles = 16'd1;
    tick();
    bus.start = 1'b0;
    check("b2b_restart_busy", 32'(bus.busy), 32'd1);
    check("b2b_restart_pulse", 32'(bus.pulse_out), 32'd1);
    check("b2b_restart_sent", bus.pulses_sent, 32'd1);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      if (bus.done) got = 1'b1;
      else tick();
    end
    check("b2b_restart_done", 32'(got), 32'd1);
    tick();

    // Reset during a HIGH phase.
    bus.start = 1'b1; bus.num_pulses = 32'd10; bus.high_cycles = 16'd4; bus.low_cycles = 16'd2;
    tick();
    bus.start = 1'b0;
    tick();
    check("midrst_pre_pulse", 32'(bus.pulse_out), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midrst_pulse", 32'(bus.pulse_out), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_sent", bus.pulses_sent, 32'd0);
    saw_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.done || bus.busy) saw_done = 1'b1;
      tick();
    end
    check("midrst_quiet", 32'(saw_done), 32'd0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
